// File: rtl/bram_test_pkg.sv
// Shared definitions for the BRAM readback checker: default widths, FSM state
// encoding and the expected write-port pattern.
package bram_test_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The write side stores each word's own address, zero-extended.
  function automatic logic [63:0] expected_word(input logic [63:0] addr);
    return addr;
  endfunction

endpackage

// File: rtl/bram_rd_compare.sv
// Read-data compare stage: aligns address with the 1-cycle BRAM latency and
// accumulates the mismatch count and first failing address for a pass.
module bram_rd_compare
  import bram_test_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W:0] ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

  logic              valid_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] exp_word;
  logic              mismatch;

  assign exp_word = DATA_W'(expected_word(64'(addr_d)));
  assign mismatch = valid_d && (rd_data != exp_word);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d        <= 1'b0;
      addr_d         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      valid_d <= rd_en;
      addr_d  <= rd_addr;
      if (clear) begin
        err_count      <= '0;
        first_err_addr <= '0;
      end else if (mismatch) begin
        if (err_count == '0)
          first_err_addr <= addr_d;
        // Saturate at the depth so an all-bad memory reads back as exactly 2**ADDR_W.
        if (err_count != ERR_MAX)
          err_count <= err_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_readback_checker.sv
// Walks every BRAM address once per start, issuing gated reads, and reports
// whether the read-back data matched the address pattern.
module bram_readback_checker
  import bram_test_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clk_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic              clear;

  assign clear   = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign rd_en   = (state == ST_READ) && clk_en;
  assign rd_addr = (state == ST_READ) ? ptr : '0;
  assign busy    = (state == ST_READ) || (state == ST_DRAIN);
  assign done    = (state == ST_DONE);
  assign pass    = done && (err_count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_READ;
            ptr   <= '0;
          end
        end
        ST_READ: begin
          if (clk_en) begin
            ptr <= ptr + 1'b1;
            // Last address issued: ptr wraps to 0 and the final word drains.
            if (ptr == '1)
              state <= ST_DRAIN;
          end
        end
        ST_DRAIN: state <= ST_DONE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  bram_rd_compare #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_compare (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .err_count     (err_count),
    .first_err_addr(first_err_addr)
  );

endmodule

// File: doc/bram_readback_checker.md
BRAM_READBACK_CHECKER -- requirements
Module: bram_readback_checker

Interface
REQ-001 Parameter ADDR_W, default 10, read-address width; depth = 2**ADDR_W.
REQ-002 Parameter DATA_W, default 16, read-data width; DATA_W >= ADDR_W.
REQ-003 clk  in  1  single clock; all state is updated on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle pulse that begins a readback pass; sampled only in IDLE or DONE.
REQ-006 clk_en  in  1  advance enable; a read is issued only in a cycle with clk_en=1.
REQ-007 rd_en  out  ADDR_W-independent, 1  read strobe to the BRAM read port.
REQ-008 rd_addr  out  ADDR_W  BRAM read address.
REQ-009 rd_data  in  DATA_W  BRAM read data, valid exactly 1 clk after rd_en=1.
REQ-010 busy  out  1  high in READ and DRAIN.
REQ-011 done  out  1  high in DONE.
REQ-012 pass  out  1  high in DONE when err_count==0; low otherwise.
REQ-013 err_count  out  ADDR_W+1  number of mismatching words in the current/last pass.
REQ-014 first_err_addr  out  ADDR_W  address of the first mismatch of the pass; 0 if none.

Function
REQ-015 Expected word for address A SHALL be A zero-extended to DATA_W (the pattern written by the address counter on the write port).
REQ-016 The FSM SHALL have the states IDLE, READ, DRAIN and DONE.
REQ-017 In IDLE or DONE, start=1 SHALL move to READ on the next edge and clear err_count, first_err_addr, and the read pointer to 0.
REQ-018 In READ with clk_en=1, the block SHALL drive rd_en=1 and rd_addr=ptr combinationally from registered ptr, and ptr SHALL increment on the edge.
REQ-019 In READ with clk_en=0, the block SHALL drive rd_en=0 and hold ptr.
REQ-020 When the read of address 2**ADDR_W-1 is issued, the FSM SHALL move to DRAIN and ptr SHALL wrap to 0; no read is issued in DRAIN.
REQ-021 DRAIN SHALL last exactly 1 cycle, then move to DONE.
REQ-022 Compare pipeline: valid_d<=rd_en and addr_d<=rd_addr; in a cycle with valid_d=1, rd_data is compared with expected(addr_d), independently of clk_en.
REQ-023 On mismatch, err_count SHALL increment and saturate at 2**ADDR_W; first_err_addr SHALL be loaded only when err_count==0 before that edge.
REQ-024 done and pass SHALL be asserted from the first DONE cycle; the results are held until the next start.
REQ-025 start in READ or DRAIN SHALL be ignored.
REQ-026 Outside READ, rd_en=0 and rd_addr=0.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, ptr=0, valid_d=0, addr_d=0, err_count=0, first_err_addr=0, so busy=done=pass=rd_en=0 and rd_addr=0.
REQ-028 A reset in the middle of a pass SHALL abort it without a done pulse; the next pass needs a new start.

Structure
REQ-029 The shared package bram_test_pkg SHALL hold the ADDR_W and DATA_W defaults, the state encoding, and the expected-pattern function.
REQ-030 The sub-module bram_rd_compare SHALL contain the valid_d/addr_d pipeline, the comparison, and the error-count/first-error logic; the top module holds the FSM and ptr.

Verification
REQ-031 Clean pass: BRAM model preloaded with mem[A]=A, clk_en=1 -> done after 1024+2 cycles from start, pass=1, err_count=0.
REQ-032 Single fault: mem[37]=0xFFFF -> err_count=1, first_err_addr=37, pass=0.
REQ-033 Gating: clk_en toggled 1/0 every cycle -> the read sequence 0..1023 has no gaps or repeats, done ~2048 cycles after start, result as in REQ-031.
REQ-034 Saturation: all words corrupted (e.g., mem[A]=~A) -> err_count=1024, first_err_addr=0.
REQ-035 Reset mid-pass: rst_n low at ptr=500 -> all outputs 0 at once, state IDLE; a new start gives a full clean pass.
REQ-036 Restart: start in DONE after a fault pass -> counters cleared, second clean pass gives pass=1; start pulsed during READ has no effect.
